// File: rtl/life_pkg.sv
// Shared types, rule constants and the neighbour-count helper for the
// life_grid cellular automaton.
package life_pkg;

  typedef enum logic {
    MODE_SETUP = 1'b0,
    MODE_RUN   = 1'b1
  } mode_t;

  typedef logic [8:0] rule_mask_t;

  localparam rule_mask_t CONWAY_BIRTH   = 9'b000001000;
  localparam rule_mask_t CONWAY_SURVIVE = 9'b000001100;

  // Number of live cells among the eight neighbour bits (0..8).
  function automatic logic [3:0] count_live(input logic [7:0] nbrs);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'b000, nbrs[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/life_cell.sv
// One automaton cell: holds its state and evaluates the birth/survive rule
// from its eight neighbours.
module life_cell
  import life_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] nbrs,
  input  logic [8:0] birth_mask,
  input  logic [8:0] survive_mask,
  input  logic       step_en,
  input  logic       toggle_en,
  input  logic       clear_en,
  output logic       state,
  output logic       next_state
);

  logic       state_r;
  logic [3:0] count_s;
  logic       next_s;

  assign count_s = count_live(nbrs);

  // Rule lookup: survivors index the survive mask, dead cells the birth mask.
  always_comb begin
    next_s = 1'b0;
    if (state_r) begin
      next_s = survive_mask[count_s];
    end else begin
      next_s = birth_mask[count_s];
    end
  end

  // Cell state register; clear outranks step, step outranks toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= 1'b0;
    end else if (clear_en) begin
      state_r <= 1'b0;
    end else if (step_en) begin
      state_r <= next_s;
    end else if (toggle_en) begin
      state_r <= ~state_r;
    end else begin
      state_r <= state_r;
    end
  end

  assign state      = state_r;
  assign next_state = next_s;

endmodule

// File: rtl/life_grid.sv
// Grid of life_cell instances with edge/wrap neighbour routing, cursor
// decode, generation counter and stability tracking.
module life_grid
  import life_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      setup,
  input  logic                      step,
  input  logic                      toggle,
  input  logic [$clog2(ROWS)-1:0]   cursor_row,
  input  logic [$clog2(COLS)-1:0]   cursor_col,
  input  logic                      clear,
  input  logic                      wrap,
  input  logic [8:0]                birth_mask,
  input  logic [8:0]                survive_mask,
  output logic [ROWS*COLS-1:0]      cells,
  output logic [GEN_W-1:0]          generation,
  output logic                      stable,
  output logic                      extinct
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int N  = ROWS * COLS;

  mode_t          mode_s;
  logic           step_en_s;
  logic           toggle_ok_s;
  logic [N-1:0]   cells_s;
  logic [N-1:0]   next_s;
  logic [N-1:0]   hit_s;
  logic [GEN_W-1:0] gen_r;
  logic           stable_r;

  // Mode is a pure function of setup; pulses are qualified by it.
  always_comb begin
    mode_s = MODE_RUN;
    if (setup) begin
      mode_s = MODE_SETUP;
    end else begin
      mode_s = MODE_RUN;
    end
  end

  assign step_en_s   = step   & (mode_s == MODE_RUN)   & ~clear;
  assign toggle_ok_s = toggle & (mode_s == MODE_SETUP) & ~clear;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nbr_s;
      logic       tog_s;

      // Neighbour k walks the 3x3 window row-major, skipping the centre.
      for (genvar k = 0; k < 9; k++) begin : g_nbr
        if (k != 4) begin : g_use
          localparam int RR = r + (k / 3) - 1;
          localparam int CC = c + (k % 3) - 1;
          localparam int WR = (RR + ROWS) % ROWS;
          localparam int WC = (CC + COLS) % COLS;
          localparam int NI = (k < 4) ? k : k - 1;
          localparam bit INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
          if (INSIDE) begin : g_in
            assign nbr_s[NI] = cells_s[RR*COLS + CC];
          end else begin : g_edge
            assign nbr_s[NI] = wrap & cells_s[WR*COLS + WC];
          end
        end
      end

      assign tog_s = toggle_ok_s & (cursor_row == RW'(r)) & (cursor_col == CW'(c));
      assign hit_s[r*COLS + c] = tog_s;

      life_cell u_cell (
        .clk          (clk),
        .reset        (reset),
        .nbrs         (nbr_s),
        .birth_mask   (birth_mask),
        .survive_mask (survive_mask),
        .step_en      (step_en_s),
        .toggle_en    (tog_s),
        .clear_en     (clear),
        .state        (cells_s[r*COLS + c]),
        .next_state   (next_s[r*COLS + c])
      );
    end
  end

  // Generation counter, wraps naturally at 2^GEN_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_r <= {GEN_W{1'b0}};
    end else if (clear) begin
      gen_r <= {GEN_W{1'b0}};
    end else if (step_en_s) begin
      gen_r <= gen_r + {{(GEN_W-1){1'b0}}, 1'b1};
    end else begin
      gen_r <= gen_r;
    end
  end

  // Stability flag: set by a step that changes nothing, dropped by any edit.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_r <= 1'b0;
    end else if (clear) begin
      stable_r <= 1'b0;
    end else if (step_en_s) begin
      stable_r <= (next_s == cells_s);
    end else if (|hit_s) begin
      stable_r <= 1'b0;
    end else begin
      stable_r <= stable_r;
    end
  end

  assign cells      = cells_s;
  assign generation = gen_r;
  assign stable     = stable_r;
  assign extinct    = (cells_s == {N{1'b0}});

endmodule

// File: tb/tb_life_grid.sv
// Directed bench for life_grid: a reference model pushes expected outputs to a
// scoreboard queue, which is drained one cycle after each stimulus edge.
module tb_life_grid;
  import life_pkg::*;

  logic        clk = 1'b0;
  logic        reset, setup, step, toggle, clear, wrap;
  logic [2:0]  cursor_row, cursor_col;
  logic [8:0]  birth_mask, survive_mask;

  logic [63:0] cells8;
  logic [15:0] gen8;
  logic        stable8, extinct8;
  logic [47:0] cells6;
  logic [15:0] gen6;
  logic        stable6, extinct6;
  logic [63:0] cells4;
  logic [3:0]  gen4;
  logic        stable4, extinct4;

  always #5 clk = ~clk;

  life_grid #(.ROWS(8), .COLS(8), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .setup(setup), .step(step), .toggle(toggle),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .clear(clear), .wrap(wrap),
    .birth_mask(birth_mask), .survive_mask(survive_mask),
    .cells(cells8), .generation(gen8), .stable(stable8), .extinct(extinct8));

  life_grid #(.ROWS(6), .COLS(8), .GEN_W(16)) dut6 (
    .clk(clk), .reset(reset), .setup(setup), .step(step), .toggle(toggle),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .clear(clear), .wrap(wrap),
    .birth_mask(birth_mask), .survive_mask(survive_mask),
    .cells(cells6), .generation(gen6), .stable(stable6), .extinct(extinct6));

  life_grid #(.ROWS(8), .COLS(8), .GEN_W(4)) dut4 (
    .clk(clk), .reset(reset), .setup(setup), .step(step), .toggle(toggle),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .clear(clear), .wrap(wrap),
    .birth_mask(birth_mask), .survive_mask(survive_mask),
    .cells(cells4), .generation(gen4), .stable(stable4), .extinct(extinct4));

  typedef struct {
    string       tag;
    int          which;
    logic [63:0] cells;
    logic [15:0] gen;
    logic        stable;
    logic        extinct;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] m_cells;
  logic [15:0] m_gen;
  logic        m_stable;
  logic [63:0] saved;

  task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  // Independent reference: counts neighbours with explicit modular indexing.
  function automatic logic [63:0] life_next(input logic [63:0] g, input logic w);
    logic [63:0] nx;
    rule_mask_t  bm, sm;
    int          n, rr, cc;
    bm = CONWAY_BIRTH;
    sm = CONWAY_SURVIVE;
    nx = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
              if (w) begin
                rr = (rr + 8) % 8;
                cc = (cc + 8) % 8;
                n += int'(g[rr*8+cc]);
              end else if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                n += int'(g[rr*8+cc]);
              end
            end
          end
        end
        nx[r*8+c] = g[r*8+c] ? sm[n] : bm[n];
      end
    end
    return nx;
  endfunction

  function automatic logic [63:0] bit_at(input int r, input int c);
    logic [63:0] v;
    v = 64'd0;
    v[r*8+c] = 1'b1;
    return v;
  endfunction

  task automatic push(input string tag, input int which);
    exp_t e;
    e.tag = tag;
    e.which = which;
    e.cells = m_cells;
    e.gen = (which == 2) ? (m_gen & 16'h000f) : m_gen;
    e.stable = m_stable;
    e.extinct = (m_cells == 64'd0);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.which)
        0: begin
          cmp({e.tag, ".cells"}, cells8, e.cells);
          cmp({e.tag, ".gen"}, {48'd0, gen8}, {48'd0, e.gen});
          cmp({e.tag, ".stable"}, {63'd0, stable8}, {63'd0, e.stable});
          cmp({e.tag, ".extinct"}, {63'd0, extinct8}, {63'd0, e.extinct});
        end
        1: begin
          cmp({e.tag, ".cells6"}, {16'd0, cells6}, e.cells);
          cmp({e.tag, ".gen6"}, {48'd0, gen6}, {48'd0, e.gen});
          cmp({e.tag, ".extinct6"}, {63'd0, extinct6}, {63'd0, e.extinct});
        end
        2: begin
          cmp({e.tag, ".cells4"}, cells4, e.cells);
          cmp({e.tag, ".gen4"}, {60'd0, gen4}, {48'd0, e.gen});
          cmp({e.tag, ".stable4"}, {63'd0, stable4}, {63'd0, e.stable});
        end
        default: cmp({e.tag, ".bad_entry"}, 64'd1, 64'd0);
      endcase
    end
  endtask

  task automatic do_toggle(input string tag, input int r, input int c);
    cursor_row = 3'(r);
    cursor_col = 3'(c);
    toggle = 1'b1;
    m_cells = m_cells ^ bit_at(r, c);
    m_stable = 1'b0;
    push(tag, 0);
    tick();
    toggle = 1'b0;
  endtask

  task automatic do_step(input string tag);
    logic [63:0] nx;
    step = 1'b1;
    nx = life_next(m_cells, wrap);
    m_stable = (nx == m_cells);
    m_cells = nx;
    m_gen = m_gen + 16'd1;
    push(tag, 0);
    push(tag, 2);
    tick();
    step = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    m_cells = 64'd0;
    m_gen = 16'd0;
    m_stable = 1'b0;
    push(tag, 0);
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; setup = 1'b1; step = 1'b0; toggle = 1'b0; clear = 1'b0;
    wrap = 1'b0; cursor_row = 3'd0; cursor_col = 3'd0;
    birth_mask = CONWAY_BIRTH; survive_mask = CONWAY_SURVIVE;
    m_cells = 64'd0; m_gen = 16'd0; m_stable = 1'b0;
    tick();
    push("reset", 0); push("reset", 1); push("reset", 2);
    tick();
    reset = 1'b0;

    // Blinker: horizontal -> vertical -> horizontal.
    do_toggle("blk_t0", 3, 2);
    do_toggle("blk_t1", 3, 3);
    do_toggle("blk_t2", 3, 4);
    setup = 1'b0;
    do_step("blk_s1");
    cmp("blinker_vertical", cells8, bit_at(2, 3) | bit_at(3, 3) | bit_at(4, 3));
    cmp("blinker_gen1", {48'd0, gen8}, 64'd1);
    cmp("blinker_unstable", {63'd0, stable8}, 64'd0);
    toggle = 1'b1;
    push("run_toggle_ignored", 0);
    tick();
    toggle = 1'b0;
    do_step("blk_s2");
    cmp("blinker_row", cells8, bit_at(3, 2) | bit_at(3, 3) | bit_at(3, 4));
    cmp("blinker_gen2", {48'd0, gen8}, 64'd2);

    // Block still life, then an edit drops stable.
    do_clear("clr_block");
    setup = 1'b1;
    do_toggle("blk2_a", 2, 2);
    do_toggle("blk2_b", 2, 3);
    do_toggle("blk2_c", 3, 2);
    do_toggle("blk2_d", 3, 3);
    setup = 1'b0;
    do_step("block_step");
    cmp("block_stable", {63'd0, stable8}, 64'd1);
    setup = 1'b1;
    do_toggle("block_edit", 0, 0);
    cmp("block_edit_unstable", {63'd0, stable8}, 64'd0);

    // Glider on the torus returns home after 32 generations.
    do_clear("clr_glider");
    do_toggle("gl_a", 1, 2);
    do_toggle("gl_b", 2, 3);
    do_toggle("gl_c", 3, 1);
    do_toggle("gl_d", 3, 2);
    do_toggle("gl_e", 3, 3);
    saved = m_cells;
    setup = 1'b0;
    wrap = 1'b1;
    for (int i = 0; i < 32; i++) do_step("glider_wrap");
    cmp("glider_home", cells8, saved);
    cmp("glider_gen32", {48'd0, gen8}, 64'd32);

    // Glider heading into the origin corner with dead edges.
    do_clear("clr_corner");
    setup = 1'b1;
    wrap = 1'b0;
    do_toggle("gc_a", 1, 1);
    do_toggle("gc_b", 1, 2);
    do_toggle("gc_c", 1, 3);
    do_toggle("gc_d", 2, 1);
    do_toggle("gc_e", 3, 2);
    setup = 1'b0;
    for (int i = 0; i < 12; i++) do_step("glider_edge");

    // clear and step in the same RUN cycle at generation 5.
    do_clear("clr_pri");
    setup = 1'b1;
    do_toggle("pri_a", 4, 1);
    do_toggle("pri_b", 4, 2);
    do_toggle("pri_c", 4, 3);
    setup = 1'b0;
    for (int i = 0; i < 5; i++) do_step("pri_step");
    cmp("pri_gen5", {48'd0, gen8}, 64'd5);
    step = 1'b1;
    do_clear("clear_over_step");
    step = 1'b0;
    cmp("clear_extinct", {63'd0, extinct8}, 64'd1);

    // Out-of-range cursor on the 6-row grid; step ignored in SETUP.
    setup = 1'b1;
    do_toggle("oor_a", 2, 2);
    do_toggle("oor_b", 7, 0);
    saved = m_cells;
    m_cells = bit_at(2, 2);
    push("oor_6row", 1);
    tick();
    m_cells = saved;
    step = 1'b1;
    push("setup_step_ignored", 0);
    tick();
    step = 1'b0;

    // 4-bit generation counter wraps after 16 steps.
    do_clear("clr_gen4");
    setup = 1'b0;
    for (int i = 0; i < 15; i++) do_step("gen4_count");
    cmp("gen4_at15", {60'd0, gen4}, 64'd15);
    do_step("gen4_wrap");
    cmp("gen4_zero", {60'd0, gen4}, 64'd0);
    cmp("gen16_at16", {48'd0, gen8}, 64'd16);

    // Reset outranks a concurrent step.
    setup = 1'b1;
    do_toggle("pre_rst", 5, 5);
    setup = 1'b0;
    reset = 1'b1; step = 1'b1; toggle = 1'b1;
    m_cells = 64'd0; m_gen = 16'd0; m_stable = 1'b0;
    push("reset_step", 0); push("reset_step", 1); push("reset_step", 2);
    tick();
    reset = 1'b0; step = 1'b0; toggle = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
